// File: rtl/ccg_stream_eval.sv
// Purpose: per-channel evaluation of two fixed Boolean functions (fa, fb) over packed input vectors, with a signature and an accepted-vector count.
// Latency: PIPE cycles from input acceptance to out_valid; 1 vector/cycle while out_ready is high.
// Backpressure: out_ready low stalls the last stage; bubbles collapse upstream, and in_ready drops once all PIPE stages are full.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    input handshake; in_data holds channel c at [c*N_IN +: N_IN]
//   out_valid/out_ready  output handshake; out_data holds channel c at [2c +: 2] as {fb, fa}
//   sig_clr, sig         signature clear and running rotate-XOR signature of delivered results
//   vec_cnt              saturating count of accepted input vectors
module ccg_stream_eval #(
    parameter int N_IN  = 4,
    parameter int N_CH  = 1,
    parameter int PIPE  = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*N_CH-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N_CH-1:0]      out_data,
    input  logic                   sig_clr,
    output logic [2*N_CH-1:0]      sig,
    output logic [CNT_W-1:0]       vec_cnt
);

    localparam int W = 2 * N_CH;

    // Both functions for every channel, packed as {fb, fa} per channel.
    function automatic logic [W-1:0] eval_vec(input logic [N_IN*N_CH-1:0] din);
        logic [W-1:0]    r;
        logic [N_IN-1:0] x;
        r = '0;
        for (int c = 0; c < N_CH; c++) begin
            x          = din[c*N_IN +: N_IN];
            r[2*c]     = ~x[N_IN-2] & ~x[N_IN-1];
            r[2*c+1]   = ~(x[0] & ~x[N_IN-1])
                       & ~(((x[1] & x[2]) | (~x[0] & ~x[2])) & x[N_IN-1]);
        end
        return r;
    endfunction

    logic [PIPE-1:0] stg_v;
    logic [W-1:0]    stg_d [PIPE];
    logic [PIPE-1:0] adv;
    logic [PIPE-1:0] ld;
    logic [PIPE-1:0] src_v;
    logic [W-1:0]    src_d [PIPE];
    logic            in_acc;
    logic            out_acc;

    // Walk from the output back to the input: a stage advances when it is
    // full and the stage below it can take data this cycle; a stage can load
    // when it is empty or advancing. This lets a full pipeline move every
    // cycle while out_ready is high.
    always_comb begin
        logic free;
        free = out_ready;
        adv  = '0;
        ld   = '0;
        for (int k = PIPE - 1; k >= 0; k--) begin
            adv[k] = stg_v[k] & free;
            ld[k]  = ~stg_v[k] | adv[k];
            free   = ld[k];
        end
    end

    // Held low during reset so nothing is counted or captured while the
    // pipeline is being cleared.
    assign in_ready  = ~rst & ld[0];
    assign in_acc    = in_valid & in_ready;
    assign out_valid = stg_v[PIPE-1];
    assign out_data  = stg_d[PIPE-1];
    assign out_acc   = out_valid & out_ready;

    // Source of each stage: stage 0 takes the freshly evaluated input, the
    // others take the stage above them.
    always_comb begin
        src_v[0] = in_acc;
        src_d[0] = eval_vec(in_data);
        for (int k = 1; k < PIPE; k++) begin
            src_v[k] = stg_v[k-1];
            src_d[k] = stg_d[k-1];
        end
    end

    // Data registers only capture real vectors, so the last stage keeps its
    // value while stalled and idle stages do not toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_v <= '0;
            for (int k = 0; k < PIPE; k++) begin
                stg_d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                if (ld[k]) begin
                    stg_v[k] <= src_v[k];
                    if (src_v[k]) begin
                        stg_d[k] <= src_d[k];
                    end
                end
            end
        end
    end

    // Signature folds each delivered result into a 1-bit left rotate of the
    // running value; a clear drops the old value but still folds in a result
    // delivered in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig     <= '0;
            vec_cnt <= '0;
        end else begin
            if (sig_clr) begin
                sig <= out_acc ? out_data : '0;
            end else if (out_acc) begin
                sig <= {sig[W-2:0], sig[W-1]} ^ out_data;
            end
            if (in_acc && (vec_cnt != {CNT_W{1'b1}})) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ccg_stream_eval.sv
// Purpose: scoreboard bench for ccg_stream_eval (default build, CNT_W=2 build, 2-channel PIPE=3 build).
// Latency: expected results are queued on input handshake and checked on output handshake.
// Backpressure: out_ready is driven directly by the stimulus (held, released, randomised).
module tb_ccg_stream_eval;

    localparam int PIPE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, sig_clr;
    logic [3:0]  in_data;
    logic        in_ready, out_valid;
    logic [1:0]  out_data, sig;
    logic [15:0] vec_cnt;

    logic        s_in_ready, s_out_valid;
    logic [1:0]  s_out_data, s_sig, s_vec_cnt;

    logic        mc_in_valid, mc_out_ready;
    logic [9:0]  mc_in_data;
    logic        mc_in_ready, mc_out_valid;
    logic [3:0]  mc_out_data, mc_sig;
    logic [15:0] mc_vec_cnt;

    ccg_stream_eval dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sig_clr(sig_clr), .sig(sig), .vec_cnt(vec_cnt)
    );

    ccg_stream_eval #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .sig_clr(sig_clr), .sig(s_sig), .vec_cnt(s_vec_cnt)
    );

    ccg_stream_eval #(.N_IN(5), .N_CH(2), .PIPE(3)) dut_mc (
        .clk(clk), .rst(rst), .in_valid(mc_in_valid), .in_ready(mc_in_ready), .in_data(mc_in_data),
        .out_valid(mc_out_valid), .out_ready(mc_out_ready), .out_data(mc_out_data),
        .sig_clr(sig_clr), .sig(mc_sig), .vec_cnt(mc_vec_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the two functions stated per channel, with fb split on the top bit.
    function automatic int ref_eval(input int x, input int nin, input int nch);
        int r, s, b0, b1, b2, hi, nh, fa, fb;
        r = 0;
        for (int c = 0; c < nch; c++) begin
            s  = (x >> (c * nin)) & ((1 << nin) - 1);
            b0 = s & 1;
            b1 = (s >> 1) & 1;
            b2 = (s >> 2) & 1;
            hi = (s >> (nin - 1)) & 1;
            nh = (s >> (nin - 2)) & 1;
            fa = (hi == 0 && nh == 0) ? 1 : 0;
            if (hi != 0) fb = ((b1 == 1 && b2 == 1) || (b0 == 0 && b2 == 0)) ? 0 : 1;
            else         fb = (b0 == 0) ? 1 : 0;
            r = r | ((fa | (fb << 1)) << (2 * c));
        end
        return r;
    endfunction

    function automatic int rotl(input int s, input int w);
        return ((s << 1) | (s >> (w - 1))) & ((1 << w) - 1);
    endfunction

    // ---------------- main scoreboard ----------------
    int   qd[$];
    int   qc[$];
    int   out_log[$];
    int   out_cyc[$];
    int   msig = 0;
    int   cnt  = 0;
    int   cyc  = 0;
    bit   lat_chk = 1'b0;
    bit   prev_hold = 1'b0;
    logic [1:0] prev_data = '0;

    always @(negedge clk) begin
        int ed, ec;
        cyc++;
        if (rst) begin
            chk("in_ready_during_rst", in_ready, 0);
            qd.delete();
            qc.delete();
            msig      = 0;
            cnt       = 0;
            prev_hold = 1'b0;
        end else begin
            chk("sig", sig, msig);
            chk("vec_cnt", vec_cnt, (cnt > 65535) ? 65535 : cnt);
            chk("sat_vec_cnt", s_vec_cnt, (cnt > 3) ? 3 : cnt);
            chk("sat_sig", s_sig, msig);
            chk("sat_in_ready", s_in_ready, in_ready);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (qd.size() == 0) chk("no_stale_out", out_valid, 0);
            if (out_valid && out_ready) begin
                if (qd.size() != 0) begin
                    ed = qd.pop_front();
                    ec = qc.pop_front();
                    chk("out_data", out_data, ed);
                    chk("sat_out_data", s_out_data, ed);
                    chk("sat_out_valid", s_out_valid, 1);
                    if (lat_chk) chk("latency", cyc - ec, PIPE);
                    msig = sig_clr ? ed : (rotl(msig, 2) ^ ed);
                    out_log.push_back(int'(out_data));
                    out_cyc.push_back(cyc);
                end
            end else if (sig_clr) begin
                msig = 0;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (in_valid && in_ready) begin
                qd.push_back(ref_eval(int'(in_data), 4, 1));
                qc.push_back(cyc);
                if (cnt < 100000) cnt++;
            end
        end
    end

    // ---------------- multi-channel scoreboard ----------------
    int mq[$];
    int msig2 = 0;
    int mcnt  = 0;

    always @(negedge clk) begin
        int ed;
        if (rst) begin
            chk("mc_in_ready_during_rst", mc_in_ready, 0);
            mq.delete();
            msig2 = 0;
            mcnt  = 0;
        end else begin
            chk("mc_sig", mc_sig, msig2);
            chk("mc_vec_cnt", mc_vec_cnt, mcnt);
            if (mq.size() == 0) chk("mc_no_stale_out", mc_out_valid, 0);
            if (mc_out_valid && mc_out_ready) begin
                if (mq.size() != 0) begin
                    ed = mq.pop_front();
                    chk("mc_out_data", mc_out_data, ed);
                    msig2 = sig_clr ? ed : (rotl(msig2, 4) ^ ed);
                end
            end else if (sig_clr) begin
                msig2 = 0;
            end
            if (mc_in_valid && mc_in_ready) begin
                mq.push_back(ref_eval(int'(mc_in_data), 5, 2));
                mcnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] x);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accepted", in_ready, 1);
        sync();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((qd.size() != 0 || out_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (qd.size() == 0 && !out_valid), 1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        sig_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int tv[7]    = '{0, 1, 8, 9, 14, 13, 15};
    int te[7]    = '{3, 1, 0, 2, 0, 2, 0};
    int bp[5]    = '{5, 10, 3, 12, 7};
    int sat_e[6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        int base, acc, n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sig_clr = 1'b0;
        mc_in_valid = 1'b0; mc_in_data = '0; mc_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sig", sig, 0);
        chk("rst_vec_cnt", vec_cnt, 0);
        sync();

        // Truth table with latency check, back-to-back inputs.
        base    = out_log.size();
        lat_chk = 1'b1;
        for (int i = 0; i < 7; i++) send(4'(tv[i]));
        drain();
        lat_chk = 1'b0;
        chk("truth_count", out_log.size() - base, 7);
        for (int i = 0; i < 7; i++) chk($sformatf("truth_%0d", i), out_log[base+i], te[i]);
        sync();

        // Signature sequence and clear.
        do_reset();
        send(4'b0000); drain(); chk("sig_after_1", sig, 2'b11); sync();
        send(4'b0001); drain(); chk("sig_after_2", sig, 2'b10); sync();
        send(4'b1001); drain(); chk("sig_after_3", sig, 2'b11); sync();
        sig_clr = 1'b1;
        sync();
        sig_clr = 1'b0;
        @(negedge clk);
        chk("sig_clr", sig, 0);
        sync();

        // Backpressure: five offered with the output stalled.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(bp[acc]);
            @(negedge clk);
            if (i == 2) chk("bp_in_ready_3rd", in_ready, 0);
            if (in_ready) acc++;
            sync();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 2);
        base      = out_cyc.size();
        out_ready = 1'b1;
        for (int i = acc; i < 5; i++) send(4'(bp[i]));
        drain();
        chk("bp_out_count", out_cyc.size() - base, 5);
        chk("bp_no_gap", out_cyc[base+4] - out_cyc[base], 4);
        sync();

        // Counter saturation on the CNT_W=2 build.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(4'($urandom));
            @(negedge clk);
            chk($sformatf("sat_seq_%0d", i), s_vec_cnt, sat_e[i]);
            sync();
        end
        drain();
        sync();

        // Reset with two vectors in flight.
        out_ready = 1'b0;
        send(4'b0000);
        send(4'b0001);
        base = out_log.size();
        rst  = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_out_data", out_data, 0);
        chk("mid_sig", sig, 0);
        chk("mid_vec_cnt", vec_cnt, 0);
        sync();
        out_ready = 1'b1;
        repeat (10) sync();
        chk("mid_no_stale", out_log.size() - base, 0);

        // Randomised traffic, clears and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            sig_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            sync();
        end
        rst = 1'b0; in_valid = 1'b0; sig_clr = 1'b0; out_ready = 1'b1;
        drain();
        sync();

        // Two-channel build: directed vector then random traffic.
        mc_in_valid = 1'b1;
        mc_in_data  = {5'b10001, 5'b00000};
        sync();
        mc_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mc_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mc_directed_valid", mc_out_valid, 1);
        chk("mc_directed_data", mc_out_data, 4'b1011);
        sync();
        for (int i = 0; i < 200; i++) begin
            mc_in_valid  = ($urandom_range(0, 1) != 0);
            mc_in_data   = 10'($urandom);
            mc_out_ready = ($urandom_range(0, 3) != 0);
            sync();
        end
        mc_in_valid  = 1'b0;
        mc_out_ready = 1'b1;
        repeat (10) sync();
        chk("mc_drained", mq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ccg_stream_eval.md
Name: ccg_stream_eval

Overview:
- Parametrised, pipelined successor to the team's 4-input generated logic benchmarks.
- Evaluates two fixed Boolean functions per channel over N_CH packed input vectors.
- Moves vectors through a PIPE-deep valid/ready pipeline and keeps an accepted-vector counter.
- Keeps a rotating XOR signature of all delivered results, so a characterised netlist can be exercised in stream and compared by signature on hardware or in simulation.

Parameters:
- N_IN, 4: bits per channel input vector; legal range 4 to 16.
- N_CH, 1: number of independent channels; legal range 1 to 8.
- PIPE, 2: pipeline stages from input acceptance to output; legal range 1 to 4.
- CNT_W, 16: width of the accepted-vector counter.

Ports:
- clk  input  1  Sole clock; all state updates on its rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Input vector present.
- in_ready  output  1  Block can accept this cycle.
- in_data  input  N_IN*N_CH  Channel c occupies bits [c*N_IN +: N_IN].
- out_valid  output  1  Result present.
- out_ready  input  1  Consumer accepts result.
- out_data  output  2*N_CH  Channel c result at [2c +: 2]; bit 2c = fa, bit 2c+1 = fb.
- sig_clr  input  1  Clear signature register.
- sig  output  2*N_CH  Running signature.
- vec_cnt  output  CNT_W  Number of accepted input vectors, saturating.

Behaviour:
- Functions, per channel, with x the channel's slice:
  - fa = ~x[N_IN-2] & ~x[N_IN-1]
  - fb = ~(x[0] & ~x[N_IN-1]) & ~(((x[1] & x[2]) | (~x[0] & ~x[2])) & x[N_IN-1])
  - Computed combinationally from the stage-0 input, then carried through the pipeline registers.
- Pipeline:
  - PIPE register stages, each holding a valid bit and 2*N_CH data bits.
  - Stage k loads from stage k-1 (stage 0 loads from the input) when stage k is empty or stage k is itself advancing.
  - The last stage advances on out_valid & out_ready.
  - in_ready = ~v[0] | adv[0]. No combinational path from in_data to out_data.
- Latency: a vector accepted in cycle t appears on out_data with out_valid=1 in cycle t+PIPE when out_ready is held 1.
- Throughput and order:
  - Throughput is 1 vector per cycle while out_ready=1.
  - With out_ready=0, up to PIPE vectors are held, then in_ready=0.
  - No vector is dropped or duplicated; order is preserved.
- Output stability: while out_valid=1 and out_ready=0, out_data holds stable.
- vec_cnt:
  - Increments by 1 on each in_valid & in_ready.
  - Saturates at 2^CNT_W - 1 and never wraps.
- Signature, with W = 2*N_CH:
  - On each output handshake, sig <= rotl1(sig) ^ out_data, where rotl1 is a 1-bit left rotate (bit W-1 wraps into bit 0).
  - sig_clr=1 sets sig to 0 in the next cycle.
  - If sig_clr and a handshake coincide, sig <= out_data (clear takes priority over the old value; the current result is still folded in).
- Reset:
  - rst=1 clears all stage valid bits, sig and vec_cnt; stage data registers are also zeroed.
  - Outputs after reset: out_valid=0, out_data=0, sig=0, vec_cnt=0, in_ready=1 from the first cycle with rst=0. During rst=1, in_ready=0.
  - Reset mid-stream discards all in-flight vectors; nothing is emitted for them.
- Simultaneous input and output handshakes in one cycle with the pipeline full are legal and sustain full rate.

Test Plan:
- Truth check (N_IN=4, N_CH=1, PIPE=2, out_ready=1):
  - Stimulus: in_data 0000, 0001, 1000, 1001, 1110, 1101, 1111 on consecutive cycles.
  - Required: out_data {fb,fa} = 11, 01, 00, 10, 00, 10, 00, each 2 cycles after acceptance.
- Signature:
  - Stimulus: after reset, deliver 0000, 0001, 1001.
  - Required: sig = 11, then 10, then 11.
  - Stimulus: assert sig_clr alone.
  - Required: sig = 00 the next cycle.
- Backpressure:
  - Stimulus: out_ready=0 with 5 vectors offered.
  - Required: exactly 2 accepted; in_ready=0 from the 3rd cycle; out_data stable.
  - Stimulus: release out_ready.
  - Required: the 5 vectors emerge in order with no gaps once flowing.
- Counter saturation:
  - Stimulus: CNT_W=2, accept 6 vectors.
  - Required: vec_cnt = 1, 2, 3, 3, 3, 3.
- Reset mid-operation:
  - Stimulus: rst=1 for 1 cycle with 2 vectors in flight.
  - Required: out_valid=0, sig=0, vec_cnt=0; no stale vector appears afterwards.
- Multi-channel:
  - Stimulus: N_IN=5, N_CH=2, in_data {ch1=10001, ch0=00000}.
  - Required: out_data = {10, 11}.
